dcache_nway: RTL and testbench

//  Parametrised N-way set-associative write-back data cache. It replaces the fixed data-memory system that sits between cpu_top's

---
 rtl/dcache_nway_if.sv | 15 +
 rtl/dcache_nway.sv | 217 +++++++++++++++++++++
 tb/tb_dcache_nway.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_nway_if.sv
// CPU-side request/response bundle of the data cache.
// The CPU is the master and drives the request; the cache is the slave and returns spo/cready.
interface dcache_nway_if #(
    parameter int DATA_W = 32
);
    logic              cvalid;
    logic              cpu_req_rw;
    logic [31:0]       a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] spo;
    logic              cready;

    modport master (output cvalid, cpu_req_rw, a, d, input spo, cready);
    modport slave  (input cvalid, cpu_req_rw, a, d, output spo, cready);
endinterface

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with LRU replacement,
// line-wide backing-memory port and clearable hit/miss/write-back counters.
//
// state | meaning
// IDLE  | waiting for cvalid; latches the request
// TAG   | lookup: hit completes the access, miss picks a victim
// WB    | writing the dirty victim line back to memory
// FILL  | fetching the requested line into the victim way
// DONE  | raises cready for one cycle, then back to IDLE
module dcache_nway #(
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int WAYS    = 2,
    parameter int BLOCK_W = 2,
    parameter int LINE_W  = DATA_W << BLOCK_W
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    dcache_nway_if.slave      cpu,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              ctr_clr,
    output logic [31:0]       miss,
    output logic [31:0]       total,
    output logic [31:0]       wb
);
    localparam int SETS   = 1 << INDEX_W;
    localparam int OFF_LO = BLOCK_W + 2;
    localparam int TAG_W  = 32 - INDEX_W - OFF_LO;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, TAG, WB, FILL, DONE} state_t;
    state_t state;

    logic [LINE_W-1:0] data_arr  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
    logic [WAY_W-1:0]  age_arr   [SETS][WAYS];
    logic [WAYS-1:0]   valid_arr [SETS];
    logic [WAYS-1:0]   dirty_arr [SETS];

    logic               req_rw;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [BLOCK_W-1:0] req_off;
    logic [DATA_W-1:0]  req_d;
    logic               first_tag;
    logic [WAY_W-1:0]   vic_way;

    logic               hit, has_inv;
    logic [WAY_W-1:0]   hit_way, inv_way, lru_way, vic_sel;
    logic [LINE_W-1:0]  hit_line, vic_line;
    logic [TAG_W-1:0]   vic_tag;
    logic [31:0]        fill_addr;
    logic               inc_total, inc_miss, inc_wb;

    // The two low byte-address bits never select anything in a word-wide cache.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu.a[1:0];

    // Tag match and victim choice for the latched request's set; invalid ways beat LRU.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_arr[req_idx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_arr[req_idx][w] == AGE_MAX) begin
                lru_way = WAY_W'(w);
            end
        end
        vic_sel   = has_inv ? inv_way : lru_way;
        hit_line  = data_arr[req_idx][hit_way];
        vic_line  = data_arr[req_idx][vic_sel];
        vic_tag   = tag_arr[req_idx][vic_sel];
        fill_addr = {req_tag, req_idx, {OFF_LO{1'b0}}};
        inc_total = (state == IDLE) && cpu.cvalid && !cpu.cready;
        inc_miss  = (state == TAG) && !hit && first_tag;
        inc_wb    = (state == WB) && mem_ready;
    end

    // Data and tag storage is deliberately left unreset; valid bits qualify it.
    always_ff @(posedge cpu_clk) begin
        if (state == FILL && mem_ready) begin
            data_arr[req_idx][vic_way] <= mem_rdata;
            tag_arr[req_idx][vic_way]  <= req_tag;
        end else if (state == TAG && hit && req_rw) begin
            data_arr[req_idx][hit_way][req_off*DATA_W +: DATA_W] <= req_d;
        end
    end

    // Controller: request capture, lookup, write-back/fill sequencing and LRU/valid/dirty upkeep.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state      <= IDLE;
            cpu.spo    <= '0;
            cpu.cready <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_rw     <= 1'b0;
            req_tag    <= '0;
            req_idx    <= '0;
            req_off    <= '0;
            req_d      <= '0;
            first_tag  <= 1'b0;
            vic_way    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_arr[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    cpu.cready <= 1'b0;
                    // cready still high means this cvalid belongs to the request just finished.
                    if (cpu.cvalid && !cpu.cready) begin
                        req_rw    <= cpu.cpu_req_rw;
                        req_tag   <= cpu.a[31:OFF_LO+INDEX_W];
                        req_idx   <= cpu.a[OFF_LO+INDEX_W-1:OFF_LO];
                        req_off   <= cpu.a[OFF_LO-1:2];
                        req_d     <= cpu.d;
                        first_tag <= 1'b1;
                        state     <= TAG;
                    end
                end
                TAG: begin
                    if (hit) begin
                        if (req_rw) begin
                            dirty_arr[req_idx][hit_way] <= 1'b1;
                        end else begin
                            cpu.spo <= hit_line[req_off*DATA_W +: DATA_W];
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) begin
                                age_arr[req_idx][w] <= '0;
                            end else if (age_arr[req_idx][w] <= age_arr[req_idx][hit_way] &&
                                         age_arr[req_idx][w] != AGE_MAX) begin
                                age_arr[req_idx][w] <= age_arr[req_idx][w] + 1'b1;
                            end
                        end
                        state <= DONE;
                    end else begin
                        first_tag <= 1'b0;
                        vic_way   <= vic_sel;
                        mem_req   <= 1'b1;
                        if (valid_arr[req_idx][vic_sel] && dirty_arr[req_idx][vic_sel]) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= {vic_tag, req_idx, {OFF_LO{1'b0}}};
                            mem_wdata <= vic_line;
                            state     <= WB;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= fill_addr;
                            state    <= FILL;
                        end
                    end
                end
                WB: begin
                    if (mem_ready) begin
                        dirty_arr[req_idx][vic_way] <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_addr <= fill_addr;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        valid_arr[req_idx][vic_way] <= 1'b1;
                        dirty_arr[req_idx][vic_way] <= 1'b0;
                        mem_req <= 1'b0;
                        state   <= TAG;
                    end
                end
                DONE: begin
                    cpu.cready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Statistics counters; a clear overrides any increment in the same cycle.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            miss  <= '0;
            total <= '0;
            wb    <= '0;
        end else if (ctr_clr) begin
            miss  <= '0;
            total <= '0;
            wb    <= '0;
        end else begin
            if (inc_total) total <= total + 32'd1;
            if (inc_miss)  miss  <= miss + 32'd1;
            if (inc_wb)    wb    <= wb + 32'd1;
        end
    end
endmodule

// File: tb/tb_dcache_nway.sv
// Bench for dcache_nway: directed scenarios plus random traffic against a
// line-level cache model (recency stamps, word memory image).
module tb_dcache_nway;
    localparam int MW = 2;
    localparam int NSETS = 16;

    logic         clk;
    logic         cpu_rstn;
    logic         mem_req, mem_we, mem_ready, ctr_clr;
    logic [31:0]  mem_addr, miss, total, wb;
    logic [127:0] mem_wdata, mem_rdata;

    dcache_nway_if #(.DATA_W(32)) bus ();

    dcache_nway #(.DATA_W(32), .INDEX_W(4), .WAYS(2), .BLOCK_W(2)) dut (
        .cpu_clk  (clk),
        .cpu_rstn (cpu_rstn),
        .cpu      (bus),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .ctr_clr  (ctr_clr),
        .miss     (miss),
        .total    (total),
        .wb       (wb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input logic [31:0] la);
        logic [127:0] l;
        if (la == 32'h0) return {32'd4, 32'd3, 32'd2, 32'd1};
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = la ^ (i << 4) ^ 32'h5A00_0000;
        return l;
    endfunction

    // Backing memory as seen by the responder, and reference model state.
    logic [127:0] r_bmem [logic [31:0]];
    logic [127:0] m_bmem [logic [31:0]];
    logic [23:0]  m_tag   [NSETS][MW];
    bit           m_valid [NSETS][MW];
    bit           m_dirty [NSETS][MW];
    int           m_stamp [NSETS][MW];
    logic [127:0] m_data  [NSETS][MW];
    int           m_time = 0;
    int           m_total = 0, m_miss = 0, m_wb = 0;

    int           resp_acks = 0;
    logic [31:0]  last_wb_addr = '1, last_fill_addr = '1, last_wb_w2 = '0;

    function automatic void model_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < MW; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        m_total = 0;
        m_miss  = 0;
        m_wb    = 0;
    endfunction

    function automatic void model_access(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                                         output bit hit, output int n_mem,
                                         output logic [31:0] rdata, output logic [31:0] wb_addr);
        logic [3:0]  sidx = addr[7:4];
        int          set  = int'(addr[7:4]);
        logic [23:0] tag  = addr[31:8];
        int          off  = int'(addr[3:2]);
        logic [31:0] la   = {addr[31:4], 4'h0};
        int          slot = -1;
        hit = 0; n_mem = 0; rdata = '0; wb_addr = '1;
        for (int i = 0; i < MW; i++)
            if (m_valid[set][i] && m_tag[set][i] == tag) begin slot = i; hit = 1; end
        if (!hit) begin
            for (int i = 0; i < MW; i++)
                if (!m_valid[set][i] && slot < 0) slot = i;
            if (slot < 0) begin
                slot = 0;
                for (int i = 1; i < MW; i++)
                    if (m_stamp[set][i] < m_stamp[set][slot]) slot = i;
                if (m_dirty[set][slot]) begin
                    wb_addr = {m_tag[set][slot], sidx, 4'h0};
                    m_bmem[wb_addr] = m_data[set][slot];
                    n_mem++;
                end
            end
            m_data[set][slot]  = m_bmem.exists(la) ? m_bmem[la] : init_line(la);
            m_valid[set][slot] = 1;
            m_dirty[set][slot] = 0;
            m_tag[set][slot]   = tag;
            n_mem++;
        end
        m_time++;
        m_stamp[set][slot] = m_time;
        if (rw) begin
            m_data[set][slot][off*32 +: 32] = data;
            m_dirty[set][slot] = 1;
        end else begin
            rdata = m_data[set][slot][off*32 +: 32];
        end
    endfunction

    // Memory responder: acknowledges three cycles after it first sees mem_req.
    initial begin : responder
        int          wait_cnt;
        logic [31:0] held_addr;
        wait_cnt  = 0;
        held_addr = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt == 0) held_addr = mem_addr;
                wait_cnt++;
                if (wait_cnt == 3) begin
                    chk("mem_addr_hold", mem_addr, held_addr);
                    wait_cnt = 0;
                    resp_acks++;
                    if (mem_we) begin
                        r_bmem[mem_addr] = mem_wdata;
                        last_wb_addr     = mem_addr;
                        last_wb_w2       = mem_wdata[95:64];
                    end else begin
                        mem_rdata      = r_bmem.exists(mem_addr) ? r_bmem[mem_addr] : init_line(mem_addr);
                        last_fill_addr = mem_addr;
                    end
                    mem_ready = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_req(input bit rw, input logic [31:0] addr, input logic [31:0] data, input bit clr,
                          output logic [31:0] rd, output int lat, output bit hit);
        int          n_mem, acks0;
        logic [31:0] exp_rd, exp_wb_addr;
        bit          done;
        model_access(rw, addr, data, hit, n_mem, exp_rd, exp_wb_addr);
        if (clr) begin
            m_total = 0; m_miss = 0; m_wb = 0;
        end else begin
            m_total++;
        end
        if (!hit) m_miss++;
        if (n_mem == 2) m_wb++;
        acks0 = resp_acks;
        done  = 0;
        lat   = 0;
        @(negedge clk);
        bus.cvalid     = 1'b1;
        bus.cpu_req_rw = rw;
        bus.a          = addr;
        bus.d          = data;
        ctr_clr        = clr;
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && clr) begin
                ctr_clr = 1'b0;
                chk("clr_total", total, 0);
                chk("clr_miss", miss, 0);
                chk("clr_wb", wb, 0);
            end
            if (bus.cready) begin
                done = 1;
                lat  = cyc;
            end
        end
        rd = bus.spo;
        bus.cvalid = 1'b0;
        ctr_clr    = 1'b0;
        if (!done) chk("req_timeout", 0, 1);
        if (!rw) chk("spo", bus.spo, exp_rd);
        if (hit) chk("hit_latency", lat, 3);
        chk("total", total, m_total);
        chk("miss", miss, m_miss);
        chk("wb", wb, m_wb);
        chk("mem_traffic", resp_acks - acks0, n_mem);
        if (n_mem == 2) chk("wb_addr", last_wb_addr, exp_wb_addr);
        if (!hit) chk("fill_addr", last_fill_addr, {addr[31:4], 4'h0});
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd, a;
        int          lat, acks0, mbefore;
        bit          hit, seen;
        cpu_rstn       = 1'b0;
        bus.cvalid     = 1'b0;
        bus.cpu_req_rw = 1'b0;
        bus.a          = '0;
        bus.d          = '0;
        ctr_clr        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_cready", bus.cready, 0);
        chk("rst_spo", bus.spo, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_counters", {miss, total, wb}, 0);
        cpu_rstn = 1'b1;

        // 1: cold read of line 0
        do_req(0, 32'h0, 0, 0, rd, lat, hit);
        chk("t1_spo", rd, 1);
        chk("t1_fill_addr", last_fill_addr, 0);
        chk("t1_total", total, 1);
        chk("t1_miss", miss, 1);

        // 2: hit in the same line
        acks0 = resp_acks;
        do_req(0, 32'h4, 0, 0, rd, lat, hit);
        chk("t2_latency", lat, 3);
        chk("t2_spo", rd, 2);
        chk("t2_no_mem", resp_acks, acks0);
        chk("t2_counts", {total, miss}, {32'd2, 32'd1});

        // 3: dirty line 0 becomes the LRU victim
        do_req(1, 32'h8, 32'hDEADBEEF, 0, rd, lat, hit);
        do_req(0, 32'h100, 0, 0, rd, lat, hit);
        do_req(0, 32'h200, 0, 0, rd, lat, hit);
        chk("t3_wb_addr", last_wb_addr, 0);
        chk("t3_wb_word2", last_wb_w2, 32'hDEADBEEF);
        chk("t3_fill_addr", last_fill_addr, 32'h200);
        chk("t3_wb", wb, 1);
        chk("t3_miss", miss, 3);

        // 4: written-back data returns on refill; 0x100 was the one evicted
        do_req(0, 32'h8, 0, 0, rd, lat, hit);
        chk("t4_spo", rd, 32'hDEADBEEF);
        mbefore = int'(miss);
        do_req(0, 32'h100, 0, 0, rd, lat, hit);
        chk("t4_evicted", miss, mbefore + 1);

        // 5: clear coincident with acceptance
        do_req(0, 32'h104, 0, 1, rd, lat, hit);
        chk("t5_after", {total, miss, wb}, 0);
        do_req(0, 32'h4, 0, 0, rd, lat, hit);
        chk("t5_total", total, 1);

        // 6: reset during FILL
        @(negedge clk);
        bus.cvalid     = 1'b1;
        bus.cpu_req_rw = 1'b0;
        bus.a          = 32'h300;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        chk("t6_fill_seen", {seen, mem_we}, 2'b10);
        cpu_rstn = 1'b0;
        #1;
        chk("t6_mem_req", mem_req, 0);
        chk("t6_cready", bus.cready, 0);
        bus.cvalid = 1'b0;
        model_reset();
        @(negedge clk);
        cpu_rstn = 1'b1;
        do_req(0, 32'h4, 0, 0, rd, lat, hit);
        chk("t6_refill_spo", rd, 2);
        chk("t6_counts", {miss, total}, {32'd1, 32'd1});

        // Random traffic over a few conflicting tags in two sets.
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 4) |
                ($urandom_range(0, 3) << 2) | ($urandom_range(0, 1) << 31);
            do_req(1'($urandom_range(0, 1)), a, $urandom, 0, rd, lat, hit);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
